// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command bytes and the 16-row message ROM for the
// cafetera LCD driver.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CLEAR,
        ST_LINE2,
        ST_WRITE
    } lcd_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_PULSE,
        TX_HOLD
    } tx_phase_e;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    localparam logic [7:0] INIT_CMDS [4] = '{CMD_FUNC_SET, CMD_DISP_ON, CMD_ENTRY, CMD_CLEAR};

    localparam logic [127:0] DASH_LINE  = "-               ";
    localparam logic [127:0] BLANK_LINE = "                ";

    // Each entry is exactly 16 characters; leftmost character sits in the top byte.
    localparam logic [127:0] MSG_LINE1 [16] = '{
        "CAFETERA LISTA  ", "SELECCIONE      ", "CALENTANDO AGUA ", "PREPARANDO CAFE ",
        "SIRVIENDO       ", "CAFE LISTO      ", "SIN AGUA        ", "ERROR           ",
        DASH_LINE, DASH_LINE, DASH_LINE, DASH_LINE,
        DASH_LINE, DASH_LINE, DASH_LINE, DASH_LINE
    };

    localparam logic [127:0] MSG_LINE2 [16] = '{
        "INSERTE MONEDA  ", "TIPO DE CAFE    ", "ESPERE...       ", "ESPERE...       ",
        "NO RETIRE VASO  ", "RETIRE SU VASO  ", "RELLENE DEPOSITO", "LLAME A SERVICIO",
        BLANK_LINE, BLANK_LINE, BLANK_LINE, BLANK_LINE,
        BLANK_LINE, BLANK_LINE, BLANK_LINE, BLANK_LINE
    };

    function automatic logic [7:0] msg_char(input logic [3:0] row, input logic [4:0] col);
        logic [127:0] line;
        int           lsb;
        line = col[4] ? MSG_LINE2[row] : MSG_LINE1[row];
        lsb  = 8 * (15 - int'(col[3:0]));
        return line[lsb +: 8];
    endfunction

    function automatic int max_cyc(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_driver_if.sv
// Display-code input and HD44780 bus of the cafetera LCD driver.
interface lcd_driver_if;
    logic [3:0] code;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic       busy;
    logic       msg_done;

    modport master (input code, output lcd_rs, lcd_rw, lcd_e, lcd_data, busy, msg_done);
    modport slave  (output code, input lcd_rs, lcd_rw, lcd_e, lcd_data, busy, msg_done);
endinterface

// File: rtl/lcd_byte_tx.sv
// One HD44780 byte write: SETUP (E low), PULSE (E high), HOLD (E low) with
// RS/DATA frozen for the whole transfer.
module lcd_byte_tx
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC      = 4,
    parameter int E_CYC          = 25,
    parameter int WAIT_CYC       = 2500,
    parameter int CLEAR_WAIT_CYC = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);
    localparam int CW = $clog2(max_cyc(SETUP_CYC, E_CYC, WAIT_CYC, CLEAR_WAIT_CYC) + 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] E_LAST     = CW'(E_CYC - 1);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(WAIT_CYC - 1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT_CYC - 1);

    tx_phase_e     phase;
    logic [CW-1:0] cnt;
    logic          long_q;
    logic [CW-1:0] hold_last;

    // done is high while idle and in the final HOLD cycle, so a waiting start
    // is taken on that edge and bytes follow each other with no gap.
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        hold_last = long_q ? CLEAR_LAST : WAIT_LAST;
        done      = (phase == TX_IDLE) || ((phase == TX_HOLD) && (cnt == hold_last));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase    <= TX_IDLE;
            cnt      <= '0;
            long_q   <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            case (phase)
                TX_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        phase <= TX_PULSE;
                        cnt   <= '0;
                        lcd_e <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                TX_PULSE: begin
                    if (cnt == E_LAST) begin
                        phase <= TX_HOLD;
                        cnt   <= '0;
                        lcd_e <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (done) begin
                        cnt <= '0;
                        if (start) begin
                            phase    <= TX_SETUP;
                            lcd_rs   <= rs;
                            lcd_data <= data;
                            long_q   <= long_wait;
                        end else begin
                            phase <= TX_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/lcd_driver.sv
// Cafetera HD44780 driver: init, clear and 2x16 message write per display code.
// Build option: define LCD_DRIVER_INIT_EN to include the power-on INIT command sequence.
module lcd_driver
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC      = 4,
    parameter int E_CYC          = 25,
    parameter int WAIT_CYC       = 2500,
    parameter int CLEAR_WAIT_CYC = 100000
) (
    input logic          clock,
    input logic          reset,
    lcd_driver_if.master bus
);
`ifdef LCD_DRIVER_INIT_EN
    localparam lcd_state_e RESET_STATE = ST_INIT;
`else
    localparam lcd_state_e RESET_STATE = ST_CLEAR;
`endif

    lcd_state_e state;
    logic [4:0] idx;
    logic [3:0] shown_code;
    logic       q_start, q_rs, q_long;
    logic [7:0] q_data;
    logic       msg_done_q;
    logic       tx_done, tx_e, tx_rs;
    logic [7:0] tx_data;

    lcd_byte_tx #(
        .SETUP_CYC(SETUP_CYC), .E_CYC(E_CYC),
        .WAIT_CYC(WAIT_CYC), .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC)
    ) u_tx (
        .clock(clock), .reset(reset),
        .start(q_start), .rs(q_rs), .data(q_data), .long_wait(q_long),
        .done(tx_done), .lcd_e(tx_e), .lcd_rs(tx_rs), .lcd_data(tx_data)
    );

    // The q_* registers hold the next byte, queued one transfer ahead; state names
    // the phase that queued byte belongs to. A byte is taken when q_start && tx_done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= RESET_STATE;
            idx        <= '0;
            shown_code <= 4'h0;
            q_start    <= 1'b0;
            q_rs       <= 1'b0;
            q_long     <= 1'b0;
            q_data     <= 8'h00;
            msg_done_q <= 1'b0;
        end else begin
            msg_done_q <= 1'b0;
            case (state)
`ifdef LCD_DRIVER_INIT_EN
                ST_INIT: if (tx_done) begin
                    if (!q_start) begin
                        q_start <= 1'b1;
                        q_rs    <= 1'b0;
                        q_data  <= INIT_CMDS[0];
                        q_long  <= 1'b0;
                    end else if (idx == 5'd3) begin
                        state      <= ST_CLEAR;
                        idx        <= '0;
                        shown_code <= bus.code;
                        q_data     <= CMD_CLEAR;
                        q_long     <= 1'b1;
                    end else begin
                        idx    <= idx + 5'd1;
                        q_data <= INIT_CMDS[idx[1:0] + 2'd1];
                        q_long <= (idx == 5'd2);
                    end
                end
`endif
                ST_CLEAR: if (tx_done) begin
                    if (!q_start) begin
                        q_start    <= 1'b1;
                        q_rs       <= 1'b0;
                        q_data     <= CMD_CLEAR;
                        q_long     <= 1'b1;
                        shown_code <= bus.code;
                    end else begin
                        state  <= ST_WRITE;
                        idx    <= '0;
                        q_rs   <= 1'b1;
                        q_data <= msg_char(shown_code, 5'd0);
                        q_long <= 1'b0;
                    end
                end
                ST_WRITE: if (tx_done) begin
                    if (!q_start) begin
                        msg_done_q <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (idx == 5'd15) begin
                        state  <= ST_LINE2;
                        idx    <= 5'd16;
                        q_rs   <= 1'b0;
                        q_data <= CMD_LINE2;
                    end else if (idx == 5'd31) begin
                        q_start <= 1'b0;
                    end else begin
                        idx    <= idx + 5'd1;
                        q_data <= msg_char(shown_code, idx + 5'd1);
                    end
                end
                ST_LINE2: if (tx_done) begin
                    state  <= ST_WRITE;
                    q_rs   <= 1'b1;
                    q_data <= msg_char(shown_code, idx);
                end
                ST_IDLE: if (bus.code != shown_code) begin
                    state      <= ST_CLEAR;
                    shown_code <= bus.code;
                    q_start    <= 1'b1;
                    q_rs       <= 1'b0;
                    q_data     <= CMD_CLEAR;
                    q_long     <= 1'b1;
                end
                default: state <= RESET_STATE;
            endcase
        end
    end

    assign bus.lcd_e    = tx_e;
    assign bus.lcd_rs   = tx_rs;
    assign bus.lcd_data = tx_data;
    assign bus.lcd_rw   = 1'b0;
    assign bus.busy     = (state != ST_IDLE);
    assign bus.msg_done = msg_done_q;
endmodule

// File: tb/tb_lcd_driver.sv
// Self-checking bench for lcd_driver: bus bytes, E timing, msg_done, busy and reset.
module tb_lcd_driver;
    localparam int S_CYC = 1;
    localparam int E_CYC = 2;
    localparam int W_CYC = 3;
    localparam int C_CYC = 5;
`ifdef LCD_DRIVER_INIT_EN
    localparam bit INIT_ON = 1'b1;
`else
    localparam bit INIT_ON = 1'b0;
`endif

    logic clock;
    logic reset;
    lcd_driver_if bus ();

    lcd_driver #(
        .SETUP_CYC(S_CYC), .E_CYC(E_CYC), .WAIT_CYC(W_CYC), .CLEAR_WAIT_CYC(C_CYC)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         cyc          = 0;
    int         mdone_cnt    = 0;
    int         exp_done     = 0;
    logic       e_prev       = 1'b0;
    logic [8:0] cap_q [$];
    int         cap_cyc [$];
    logic [8:0] exp_q [$];

    always @(posedge clock) cyc <= cyc + 1;

    // Bus monitor: one entry {rs, data} per rising E, plus the cycle it rose in.
    always @(negedge clock) begin
        if (bus.lcd_e && !e_prev) begin
            cap_q.push_back({bus.lcd_rs, bus.lcd_data});
            cap_cyc.push_back(cyc);
        end
        e_prev <= bus.lcd_e;
        if (bus.msg_done) mdone_cnt <= mdone_cnt + 1;
    end

    function automatic string row_text(input int c);
        case (c)
            0: return {"CAFETERA LISTA  ", "INSERTE MONEDA  "};
            1: return {"SELECCIONE      ", "TIPO DE CAFE    "};
            2: return {"CALENTANDO AGUA ", "ESPERE...       "};
            3: return {"PREPARANDO CAFE ", "ESPERE...       "};
            4: return {"SIRVIENDO       ", "NO RETIRE VASO  "};
            5: return {"CAFE LISTO      ", "RETIRE SU VASO  "};
            6: return {"SIN AGUA        ", "RELLENE DEPOSITO"};
            7: return {"ERROR           ", "LLAME A SERVICIO"};
            default: return {"-               ", "                "};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic build_expected(input bit with_init, input int row);
        string txt;
        txt = row_text(row);
        exp_q.delete();
        if (with_init) begin
            exp_q.push_back(9'h038);
            exp_q.push_back(9'h00C);
            exp_q.push_back(9'h006);
            exp_q.push_back(9'h001);
        end
        exp_q.push_back(9'h001);
        for (int i = 0; i < 32; i++) begin
            if (i == 16) exp_q.push_back(9'h0C0);
            exp_q.push_back({1'b1, txt.getc(i)});
        end
    endtask

    task automatic compare_msg(input string tag);
        check($sformatf("%s_len", tag), cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), {23'd0, cap_q[i]}, {23'd0, exp_q[i]});
    endtask

    // Every byte occupies SETUP+E+wait cycles, the wait being long only after a clear.
    task automatic check_gaps(input string tag);
        int exp_gap;
        for (int k = 1; k < cap_cyc.size(); k++) begin
            exp_gap = S_CYC + E_CYC + ((cap_q[k-1] == 9'h001) ? C_CYC : W_CYC);
            check($sformatf("%s_gap%0d", tag, k), cap_cyc[k] - cap_cyc[k-1], exp_gap);
        end
    endtask

    task automatic clear_capture();
        cap_q.delete();
        cap_cyc.delete();
    endtask

    task automatic wait_done(input string tag);
        int start_cnt;
        int n;
        start_cnt = mdone_cnt;
        n = 0;
        while (mdone_cnt == start_cnt && n < 3000) begin
            @(negedge clock);
            n++;
        end
        #1;
        check($sformatf("%s_done_seen", tag), (mdone_cnt != start_cnt), 1);
    endtask

    task automatic start_code(input logic [3:0] c, input string tag);
        clear_capture();
        check($sformatf("%s_idle_busy", tag), bus.busy, 0);
        bus.code = c;
        @(negedge clock);
        check($sformatf("%s_busy_rise", tag), bus.busy, 1);
    endtask

    function automatic logic [3:0] pick_code(input logic [3:0] avoid);
        logic [3:0] c;
        c = 4'($urandom_range(0, 15));
        if (c == avoid) c = c + 4'd1;
        return c;
    endfunction

    initial begin
        logic [3:0] shown;
        logic [3:0] c;
        int         n;

        reset    = 1'b1;
        bus.code = 4'h0;
        shown    = 4'h0;
        repeat (3) @(negedge clock);
        check("rst_e", bus.lcd_e, 0);
        check("rst_rs", bus.lcd_rs, 0);
        check("rst_rw", bus.lcd_rw, 0);
        check("rst_data", bus.lcd_data, 0);
        check("rst_msg_done", bus.msg_done, 0);

        clear_capture();
        reset = 1'b0;
        @(negedge clock);
        check("busy_after_rst", bus.busy, 1);
        wait_done("boot");
        exp_done++;
        build_expected(INIT_ON, 0);
        compare_msg("boot");
        check_gaps("boot");
        repeat (5) @(negedge clock);
        check("boot_busy_low", bus.busy, 0);
        check("boot_done_cnt", mdone_cnt, exp_done);

        // Code 5, then two changes while it is still being written: only 3 follows.
        start_code(4'h5, "c5");
        n = 0;
        while (cap_q.size() < 10 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("c5_mid_write", (cap_q.size() >= 10), 1);
        bus.code = 4'h9;
        repeat (20) @(negedge clock);
        bus.code = 4'h3;
        wait_done("c5");
        exp_done++;
        build_expected(1'b0, 5);
        compare_msg("c5");
        check_gaps("c5");
        clear_capture();
        wait_done("c3");
        exp_done++;
        build_expected(1'b0, 3);
        compare_msg("c3");
        clear_capture();
        repeat (100) @(negedge clock);
        check("c3_no_more_bytes", cap_q.size(), 0);
        check("c3_busy_low", bus.busy, 0);
        check("c3_done_cnt", mdone_cnt, exp_done);
        shown = 4'h3;

        for (int r = 0; r < 3; r++) begin
            c = pick_code(shown);
            start_code(c, $sformatf("rnd%0d", r));
            wait_done($sformatf("rnd%0d", r));
            exp_done++;
            build_expected(1'b0, int'(c));
            compare_msg($sformatf("rnd%0d", r));
            check_gaps($sformatf("rnd%0d", r));
            shown = c;
        end
        check("rnd_done_cnt", mdone_cnt, exp_done);

        // Reset while E is high during a character, then a full restart.
        c = pick_code(shown);
        start_code(c, "rmid");
        n = 0;
        while (!(bus.lcd_e && cap_q.size() >= 5) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check("rmid_e_high", bus.lcd_e, 1);
        #2 reset = 1'b1;
        #1;
        check("rmid_async_e", bus.lcd_e, 0);
        check("rmid_async_data", bus.lcd_data, 0);
        check("rmid_async_rs", bus.lcd_rs, 0);
        @(negedge clock);
        clear_capture();
        reset = 1'b0;
        wait_done("rmid");
        exp_done++;
        build_expected(INIT_ON, int'(c));
        compare_msg("rmid");
        check_gaps("rmid");
        repeat (5) @(negedge clock);
        check("rmid_busy_low", bus.busy, 0);
        check("final_done_cnt", mdone_cnt, exp_done);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
